// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder: bus mode constants, the
// controller state encoding and the default word width.
package spi_slave_pkg;

  // Bus mode: SCK idles low, data is sampled on the rising edge,
  // and words travel MSB first.
  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  localparam int DEFAULT_DATA_BIT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a single
// delay flop used to report rising/falling edges of the synchronized level.
// Pin-to-edge-strobe latency is SYNC_STAGES clk cycles, so logic acting on
// the strobe responds SYNC_STAGES+1 clk after the pin changes.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic D,
  output logic Q,
  output logic RISE,
  output logic FALL
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   dly_q;

  // Stage 0 takes the raw pin; each following stage takes its predecessor.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], D};
  end

  // Synchronizer chain plus the edge-detect delay flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign Q    = sync_q[SYNC_STAGES-1];
  assign RISE = Q & ~dly_q;
  assign FALL = ~Q & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder (mode 0, MSB first, active-high select).
// Oversamples SCK/SEL/MOSI on clk, exchanges one DATA_BIT_WIDTH word per
// select window and presents each complete received word with a one-cycle
// RX_VALID strobe.
// Build option: define SPI_SLAVE_OVERRUN_EN to add RX_ACK / RX_OVERRUN,
// which flag a received word that was overwritten before being acknowledged.
//
// Handshake: TX_LOAD is a one-cycle strobe with no back-pressure; it is
// always accepted and overwrites the tx buffer. RX_VALID is a one-cycle
// strobe with no ready; the fabric must capture RX_DATA (or, with the
// overrun option, acknowledge with RX_ACK) before the next word completes.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = DEFAULT_DATA_BIT_WIDTH,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      SCK,
  input  logic                      SEL,
  input  logic                      MOSI,
  output logic                      MISO,
  input  logic [DATA_BIT_WIDTH-1:0] TX_DATA,
  input  logic                      TX_LOAD,
  output logic [DATA_BIT_WIDTH-1:0] RX_DATA,
  output logic                      RX_VALID,
`ifdef SPI_SLAVE_OVERRUN_EN
  input  logic                      RX_ACK,
  output logic                      RX_OVERRUN,
`endif
  output logic                      BUSY
);

  localparam int W     = DATA_BIT_WIDTH;
  // One extra bit so the count can reach W without wrapping.
  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);

  // Synchronized pin views
  logic sck_rise, sck_fall, unused_sck_level;
  logic sel_level, sel_rise, unused_sel_fall;
  logic mosi_level, unused_mosi_rise, unused_mosi_fall;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk (clk),
    .rst (rst),
    .D   (SCK),
    .Q   (unused_sck_level),
    .RISE(sck_rise),
    .FALL(sck_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sel_sync (
    .clk (clk),
    .rst (rst),
    .D   (SEL),
    .Q   (sel_level),
    .RISE(sel_rise),
    .FALL(unused_sel_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk (clk),
    .rst (rst),
    .D   (MOSI),
    .Q   (mosi_level),
    .RISE(unused_mosi_rise),
    .FALL(unused_mosi_fall)
  );

  // Controller state and datapath registers
  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     shift_tx_q, shift_tx_d;
  logic [W-1:0]     shift_rx_q, shift_rx_d;
  logic [W-1:0]     tx_buf_q, tx_buf_d;
  logic [W-1:0]     rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             word_full;

  assign word_full = (cnt_q == CNT_FULL);

  // State register plus datapath registers, all cleared by async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      tx_buf_q   <= tx_buf_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Next-state logic. Exits test the synced SEL level so a deassertion is
  // never missed, even if it coincides with word completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_rise) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (word_full)       state_d = sel_level ? ST_DONE : ST_IDLE;
        else if (!sel_level) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (!sel_level) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / output logic: buffer loads, shifting, word hand-off.
  always_comb begin
    cnt_d      = cnt_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_buf_d   = TX_LOAD ? TX_DATA : tx_buf_q;
    unique case (state_q)
      ST_IDLE: begin
        // A load in the same cycle as select detection goes straight out.
        if (sel_rise) begin
          shift_tx_d = TX_LOAD ? TX_DATA : tx_buf_q;
          cnt_d      = '0;
        end
      end
      ST_SHIFT: begin
        if (word_full) begin
          rx_data_d  = shift_rx_q;
          rx_valid_d = 1'b1;
        end else if (sel_level) begin
          if (sck_rise) begin
            shift_rx_d = {shift_rx_q[W-2:0], mosi_level};
            cnt_d      = cnt_q + 1'b1;
          end
          if (sck_fall) begin
            shift_tx_d = {shift_tx_q[W-2:0], 1'b0};
          end
        end
      end
      default: ;
    endcase
  end

  assign BUSY     = (state_q != ST_IDLE);
  assign MISO     = BUSY & shift_tx_q[W-1];
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic unacked_q, unacked_d;
  logic overrun_q, overrun_d;

  // Track whether the presented word was acknowledged before the next one.
  // An ack coinciding with RX_VALID covers the previous word only.
  always_comb begin
    unacked_d = unacked_q;
    overrun_d = overrun_q;
    if (rx_valid_q) begin
      unacked_d = 1'b1;
      if (RX_ACK)         overrun_d = 1'b0;
      else if (unacked_q) overrun_d = 1'b1;
    end else if (RX_ACK) begin
      unacked_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Overrun tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unacked_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      unacked_q <= unacked_d;
      overrun_q <= overrun_d;
    end
  end

  assign RX_OVERRUN = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master driving pins, a table of
// directed transfers, randomized transfers against a word-level model
// (tx buffer / last-received word / expected strobe count), and hand
// sequences for reset mid-transfer, same-cycle load bypass and overrun.
module tb_spi_slave;

  localparam int W    = 16;
  localparam int SYNC = 2;
  localparam int HALF = 8;  // SCK half period in clk cycles

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         SCK = 1'b0;
  logic         SEL = 1'b0;
  logic         MOSI = 1'b0;
  logic         MISO;
  logic [W-1:0] TX_DATA = '0;
  logic         TX_LOAD = 1'b0;
  logic [W-1:0] RX_DATA;
  logic         RX_VALID;
  logic         BUSY;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic         RX_ACK = 1'b0;
  logic         RX_OVERRUN;
`endif

  spi_slave #(.DATA_BIT_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .SCK       (SCK),
    .SEL       (SEL),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .TX_DATA   (TX_DATA),
    .TX_LOAD   (TX_LOAD),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
`ifdef SPI_SLAVE_OVERRUN_EN
    .RX_ACK    (RX_ACK),
    .RX_OVERRUN(RX_OVERRUN),
`endif
    .BUSY      (BUSY)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts RX_VALID cycles and logs word and time.
  int           valid_cnt = 0;
  int           valid_cyc = 0;
  logic [W-1:0] valid_word = '0;
  always @(negedge clk) begin
    if (RX_VALID) begin
      valid_cnt  = valid_cnt + 1;
      valid_cyc  = cyc;
      valid_word = RX_DATA;
    end
  end

  // Scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [W-1:0] model_buf = '0;
  logic [W-1:0] model_rx  = '0;

  task automatic load_word(input logic [W-1:0] w);
    @(negedge clk);
    TX_DATA = w;
    TX_LOAD = 1'b1;
    @(negedge clk);
    TX_LOAD = 1'b0;
  endtask

  // One SPI master transaction. Optional features: TX_LOAD aligned with
  // select detection (byp), a load mid-window (mid), reset at a bit (rst_bit).
  task automatic do_xfer(input int nbits, input logic [W-1:0] mosi_word,
                         input int rst_bit,
                         input logic byp_en, input logic [W-1:0] byp_word,
                         input logic mid_en, input logic [W-1:0] mid_word,
                         output logic [W-1:0] miso_word, output int valids,
                         output int lat);
    int v0;
    int c_last;
    miso_word = '0;
    v0        = valid_cnt;
    lat       = -1;
    c_last    = 0;
    @(negedge clk);
    SEL = 1'b1;
    if (byp_en) begin
      // Select is acted on SYNC+1 edges after the pin; present the load then.
      repeat (SYNC) @(negedge clk);
      TX_DATA = byp_word;
      TX_LOAD = 1'b1;
      @(negedge clk);
      TX_LOAD = 1'b0;
      repeat (HALF - SYNC - 1) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    check("busy_active", BUSY, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst = 1'b1;
        #1;
        check("rst_miso", MISO, 1'b0);
        check("rst_rx_data", RX_DATA, '0);
        check("rst_rx_valid", RX_VALID, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        SCK  = 1'b0;
        SEL  = 1'b0;
        MOSI = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        valids = valid_cnt - v0;
        return;
      end
      MOSI = (i < W) ? mosi_word[W-1-i] : 1'b0;
      if (mid_en && i == nbits / 2) begin
        TX_DATA = mid_word;
        TX_LOAD = 1'b1;
        @(negedge clk);
        TX_LOAD = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (i < W) miso_word = {miso_word[W-2:0], MISO};
      if (i == W - 1) c_last = cyc;
      SCK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    SEL = 1'b0;
    repeat (HALF) @(negedge clk);
    check("busy_idle", BUSY, 1'b0);
    valids = valid_cnt - v0;
    if (nbits >= W) lat = valid_cyc - c_last;
  endtask

  // Compare one transfer against expectations (word-level).
  task automatic check_xfer(input int nbits, input logic [W-1:0] exp_tx,
                            input logic [W-1:0] exp_rx, input int exp_valids,
                            input logic [W-1:0] miso_word, input int valids,
                            input int lat);
    int k;
    k = (nbits < W) ? nbits : W;
    check("miso_stream", miso_word, exp_tx >> (W - k));
    check("rx_valid_count", valids, exp_valids);
    check("rx_data", RX_DATA, exp_rx);
    if (exp_valids == 1) begin
      check("rx_word_at_strobe", valid_word, exp_rx);
      // Edge acted on SYNC+1 clk after the pin, strobe one clk later.
      check("rx_valid_latency", lat, SYNC + 2);
    end
  endtask

  typedef struct {
    int           nbits;
    logic         do_load;
    logic [W-1:0] load_word;
    logic [W-1:0] mosi;
    logic [W-1:0] exp_miso;
    logic [W-1:0] exp_rx;
    int           exp_valids;
  } xfer_vec_t;

  xfer_vec_t tbl[5];

  initial begin
    logic [W-1:0] miso_w, mosi_w, pre_w, byp_w, mid_w, exp_tx;
    int           valids, lat, nb, sel;
    logic         pre_en, byp_en, mid_en;

    tbl[0] = '{16, 1'b1, 16'hA5C3, 16'h3C5A, 16'hA5C3, 16'h3C5A, 1};
    tbl[1] = '{16, 1'b0, 16'h0000, 16'h0F0F, 16'hA5C3, 16'h0F0F, 1};
    tbl[2] = '{9,  1'b0, 16'h0000, 16'h1234, 16'hA5C3, 16'h0F0F, 0};
    tbl[3] = '{16, 1'b0, 16'h0000, 16'h0001, 16'hA5C3, 16'h0001, 1};
    tbl[4] = '{20, 1'b1, 16'h5A5A, 16'hFFFF, 16'h5A5A, 16'hFFFF, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_miso", MISO, 1'b0);
    check("reset_rx_data", RX_DATA, '0);
    check("reset_rx_valid", RX_VALID, 1'b0);
    check("reset_busy", BUSY, 1'b0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("reset_overrun", RX_OVERRUN, 1'b0);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Directed table
    for (int t = 0; t < 5; t++) begin
      if (tbl[t].do_load) load_word(tbl[t].load_word);
      do_xfer(tbl[t].nbits, tbl[t].mosi, -1, 1'b0, '0, 1'b0, '0, miso_w, valids, lat);
      check_xfer(tbl[t].nbits, tbl[t].exp_miso, tbl[t].exp_rx, tbl[t].exp_valids,
                 miso_w, valids, lat);
    end
    model_buf = 16'h5A5A;
    model_rx  = 16'hFFFF;

    // Reset at bit 7: everything returns to zero, no strobe.
    load_word(16'hBEEF);
    do_xfer(16, 16'hAAAA, 7, 1'b0, '0, 1'b0, '0, miso_w, valids, lat);
    check("rst_no_valid", valids, 0);
    check("rst_rx_hold", RX_DATA, '0);
    model_buf = '0;
    model_rx  = '0;
    do_xfer(16, 16'h1234, -1, 1'b0, '0, 1'b0, '0, miso_w, valids, lat);
    check_xfer(16, 16'h0000, 16'h1234, 1, miso_w, valids, lat);
    model_rx = 16'h1234;

    // Load coinciding with select detection is sent; a load inside the
    // window only affects the next transfer.
    load_word(16'h1111);
    do_xfer(16, 16'h8001, -1, 1'b1, 16'hC0DE, 1'b1, 16'h7E57, miso_w, valids, lat);
    check_xfer(16, 16'hC0DE, 16'h8001, 1, miso_w, valids, lat);
    do_xfer(16, 16'h4002, -1, 1'b0, '0, 1'b0, '0, miso_w, valids, lat);
    check_xfer(16, 16'h7E57, 16'h4002, 1, miso_w, valids, lat);
    model_buf = 16'h7E57;
    model_rx  = 16'h4002;

    // Randomized transfers against the word-level model
    for (int r = 0; r < 24; r++) begin
      sel = $urandom_range(0, 3);
      nb  = (sel == 0) ? $urandom_range(3, 15) :
            (sel == 1) ? $urandom_range(17, 20) : W;
      mosi_w = W'($urandom);
      pre_en = 1'($urandom_range(0, 1));
      pre_w  = W'($urandom);
      byp_en = ($urandom_range(0, 4) == 0);
      byp_w  = W'($urandom);
      mid_en = ($urandom_range(0, 3) == 0);
      mid_w  = W'($urandom);
      if (pre_en) begin
        load_word(pre_w);
        model_buf = pre_w;
      end
      if (byp_en) model_buf = byp_w;
      exp_tx = model_buf;
      do_xfer(nb, mosi_w, -1, byp_en, byp_w, mid_en, mid_w, miso_w, valids, lat);
      if (mid_en) model_buf = mid_w;
      if (nb >= W) model_rx = mosi_w;
      check_xfer(nb, exp_tx, model_rx, (nb >= W) ? 1 : 0, miso_w, valids, lat);
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    // Clear any standing overrun, then two unacknowledged words.
    @(negedge clk);
    RX_ACK = 1'b1;
    @(negedge clk);
    RX_ACK = 1'b0;
    @(negedge clk);
    check("ovr_cleared", RX_OVERRUN, 1'b0);
    do_xfer(16, 16'h0F0F, -1, 1'b0, '0, 1'b0, '0, miso_w, valids, lat);
    check("ovr_first_word", RX_OVERRUN, 1'b0);
    do_xfer(16, 16'hF0F0, -1, 1'b0, '0, 1'b0, '0, miso_w, valids, lat);
    check("ovr_second_word", RX_OVERRUN, 1'b1);
    @(negedge clk);
    RX_ACK = 1'b1;
    @(negedge clk);
    RX_ACK = 1'b0;
    @(negedge clk);
    check("ovr_ack_clears", RX_OVERRUN, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
